uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART serial receiver: 8N1 frames, 16x oversampling.
- Consumes the `tick` from the baud-rate generator (M=27 gives 115200 baud at 50 MHz) on its `s_tick` input.
- Deserialises `rx` LSB-first and presents each byte with a one-cycle done strobe.
- Sits between the board RX pin and the UART receive FIFO / interface logic.

Parameters:
- DBIT, 8: data bits per frame (5..9 legal).
- SB_TICK, 16: oversample ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- s_tick  input  1  16x-baud enable pulse, one clk wide.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-cycle pulse: dout updated.
- frame_err  output  1  stop bit sampled low on last frame; sticky until next rx_done_tick.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high; all state is updated on posedge clk only.
- Input synchroniser:
  - `rx` passes through a 2-flop synchroniser (`rx_s`) before any use.
  - Both flops reset to 1.
  - Adds 2 clk latency to edge detection.
- Counters:
  - s (4 bits, tick count, wraps 15->0 in DATA).
  - n (3 bits for DBIT=8, width $clog2(DBIT)).
  - b (DBIT-bit shift register).
- Reset values: state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, armed=1.
- FSM states: IDLE, START, DATA, STOP. Counters advance only in cycles with s_tick=1.
- IDLE:
  - If armed=0: wait for rx_s=1, then set armed=1.
  - If armed=1 and rx_s=0: go to START, s=0. This transition does not need s_tick.
- START:
  - On s_tick with s==7 (mid start bit): if rx_s=0, go to DATA with s=0, n=0.
  - If rx_s=1 at that point: glitch/false start; return to IDLE with no strobe and no error.
  - Otherwise, on s_tick: s++.
- DATA:
  - On s_tick with s==15: s=0 and b={rx_s, b[DBIT-1:1]} (LSB first).
  - If n==DBIT-1, go to STOP; else n++.
  - Otherwise, on s_tick: s++.
- STOP:
  - On s_tick with s==SB_TICK-1: dout<=b, rx_done_tick<=1 for exactly the next clk, frame_err<=~rx_s, go to IDLE.
  - If rx_s=0 (framing error/break): armed<=0, so a held-low line does not retrigger.
- rx_done_tick is registered: high in the clk cycle after the final STOP s_tick. It is never high two consecutive cycles.
- dout holds its value until the next completed frame; it is never updated on a false start.
- Back-to-back frames: with a valid stop, IDLE accepts a falling edge immediately, so a zero-idle-gap stream is received without loss.
- Reset mid-frame: return to IDLE on the next edge, discard the partial byte, no strobe.
- Reset asserted together with the final stop tick: reset wins.
- s_tick arriving while in IDLE is ignored.
- No dependence on the s_tick phase relative to the start edge; sampling error is ≤1/16 bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, 16 ticks long, sampled at s==15.
  - Adds output port parity_err (1 bit, reset 0), updated together with dout on rx_done_tick.
  - parity_err = sampled parity bit XOR (^b), i.e. even parity expected.
  - Frame becomes 8E1.
- Undefined: no PARITY state and no parity_err port; frame is 8N1 exactly as above.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, PARITY}.
  - Constants OVERSAMPLE=16 and MID_SAMPLE=7.
  - The shared DBIT/SB_TICK defaults, so uart_tx can reuse them.
- Sub-module: sync_2ff (generic 2-flop bit synchroniser with reset value parameter); also reusable for other async pins.

Test Plan:
- Byte with normal stop: drive s_tick every 27 clk, send 0x55 at 432 clk/bit -> one rx_done_tick, dout=0x55, frame_err=0.
- Back-to-back frames: send 0xA3 then 0x0F with zero idle gap -> exactly two strobes, dout 0xA3 then 0x0F, no errors.
- Glitch rejection: rx low for 3 ticks (81 clk) then high -> FSM back in IDLE, no strobe, dout unchanged.
- Framing error and break: send 0xFF with the stop bit low, then hold rx low for 10 bit times -> one strobe, dout=0xFF, frame_err=1, no further strobes. After rx returns high, 0x12 is received with frame_err=0.
- Reset mid-frame: assert reset during bit 4 of 0xC6 -> no strobe, all outputs 0 next cycle. A subsequent 0x81 is received correctly.
- With UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> parity_err=0.
  - 0x07 with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the default frame geometry reused by the transmitter side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_rx_state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int MID_SAMPLE   = 7;
  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: received word, completion strobe and error flags.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DBIT = 8
);

  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

`ifdef UART_RX_PARITY_EN
  modport master (output dout, output rx_done_tick, output frame_err, output parity_err);
  modport slave  (input  dout, input  rx_done_tick, input  frame_err, input  parity_err);
`else
  modport master (output dout, output rx_done_tick, output frame_err);
  modport slave  (input  dout, input  rx_done_tick, input  frame_err);
`endif

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// RST_VAL sets the value both flops take in reset (idle level of the pin).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampling, LSB first, 8N1 by default.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and parity_err.
// The rx_if interface instance must be built with the same DBIT.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  input  logic      s_tick,
  uart_rx_if.master rx_if
);

  // s must reach SB_TICK-1 in STOP, so widen it for 1.5/2 stop bits.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  logic           w_rx_s;
  uart_rx_state_t r_state;
  logic [SW-1:0]  r_s;
  logic [NW-1:0]  r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic           r_done;
  logic           r_frame_err;
  logic           r_armed;
`ifdef UART_RX_PARITY_EN
  logic           r_par;
  logic           r_parity_err;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  // Receive state machine: start detection, bit sampling and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_b         <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // After a break the line must return high before a new start counts.
          if (!r_armed) begin
            if (w_rx_s) begin
              r_armed <= 1'b1;
            end
          end else if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == SW'(MID_SAMPLE)) begin
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == SW'(OVERSAMPLE - 1)) begin
              r_s <= '0;
              r_b <= {w_rx_s, r_b[DBIT-1:1]};
              if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_n <= r_n + NW'(1);
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (r_s == SW'(OVERSAMPLE - 1)) begin
              r_s     <= '0;
              r_par   <= w_rx_s;
              r_state <= STOP;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (r_s == SW'(SB_TICK - 1)) begin
              r_dout      <= r_b;
              r_done      <= 1'b1;
              r_frame_err <= ~w_rx_s;
              r_state     <= IDLE;
              r_s         <= '0;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par ^ (^r_b);
`endif
              if (!w_rx_s) begin
                r_armed <= 1'b0;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= '0;
        end
      endcase
    end
  end

  assign rx_if.dout         = r_dout;
  assign rx_if.rx_done_tick = r_done;
  assign rx_if.frame_err    = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err   = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx (8N1, or 8E1 with UART_RX_PARITY_EN).
module tb_uart_rx;

  localparam int BIT_CLKS = 432;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic s_tick = 1'b0;
  int   tick_cnt = 0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_strobes = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  uart_rx_if #(.DBIT(8)) rx_if ();

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .s_tick (s_tick),
    .rx_if  (rx_if)
  );

  always #10 clk = ~clk;

  // 16x baud tick: one clk every 27 clocks.
  always @(posedge clk) begin
    if (tick_cnt == 26) begin
      tick_cnt <= 0;
      s_tick   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      s_tick   <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_clks(BIT_CLKS);
  endtask

  // Drives one whole frame and queues what the receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pbit);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_v;
    e.pe = pbit ^ (^d);
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop_v);
  endtask

  // Scoreboard: each strobe pops one expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rx_if.rx_done_tick) begin
      n_strobes++;
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_strobe: observed dout 0x%0h expected no strobe", rx_if.dout);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dout", {24'd0, rx_if.dout}, {24'd0, e.d});
        chk("frame_err", {31'd0, rx_if.frame_err}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
        chk("parity_err", {31'd0, rx_if.parity_err}, {31'd0, e.pe});
`endif
      end
    end
    prev_done = rx_if.rx_done_tick;
  end

  initial begin
    int s0;
    logic [7:0] c6;
    c6 = 8'hC6;

    // Reset state
    reset = 1'b1;
    rx = 1'b1;
    wait_clks(4);
    chk("rst_dout", {24'd0, rx_if.dout}, 32'd0);
    chk("rst_done", {31'd0, rx_if.rx_done_tick}, 32'd0);
    chk("rst_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("rst_parity_err", {31'd0, rx_if.parity_err}, 32'd0);
`endif
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);

    // Single byte, valid stop
    s0 = n_strobes;
    send_frame(8'h55, 1'b1, ^8'h55);
    wait_clks(64);
    chk("b55_strobes", n_strobes - s0, 32'd1);
    chk("b55_queue", exp_q.size(), 32'd0);

    // Back-to-back frames, zero idle gap
    s0 = n_strobes;
    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    wait_clks(64);
    chk("b2b_strobes", n_strobes - s0, 32'd2);
    chk("b2b_queue", exp_q.size(), 32'd0);

    // Glitch shorter than half a bit
    s0 = n_strobes;
    rx = 1'b0;
    wait_clks(81);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("glitch_strobes", n_strobes - s0, 32'd0);
    chk("glitch_dout", {24'd0, rx_if.dout}, 32'h0F);

    // Framing error followed by a long break
    s0 = n_strobes;
    send_frame(8'hFF, 1'b0, ^8'hFF);
    rx = 1'b0;
    wait_clks(10 * BIT_CLKS);
    chk("break_strobes", n_strobes - s0, 32'd1);
    chk("break_frame_err_sticky", {31'd0, rx_if.frame_err}, 32'd1);
    chk("break_queue", exp_q.size(), 32'd0);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("break_release_strobes", n_strobes - s0, 32'd1);
    send_frame(8'h12, 1'b1, ^8'h12);
    wait_clks(64);
    chk("after_break_strobes", n_strobes - s0, 32'd2);
    chk("after_break_frame_err", {31'd0, rx_if.frame_err}, 32'd0);

    // Reset in the middle of bit 4 of 0xC6
    s0 = n_strobes;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c6[i]);
    rx = c6[4];
    wait_clks(BIT_CLKS / 2);
    reset = 1'b1;
    wait_clks(1);
    chk("midrst_dout", {24'd0, rx_if.dout}, 32'd0);
    chk("midrst_done", {31'd0, rx_if.rx_done_tick}, 32'd0);
    chk("midrst_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
    reset = 1'b0;
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    chk("midrst_strobes", n_strobes - s0, 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81);
    wait_clks(64);
    chk("post_rst_strobes", n_strobes - s0, 32'd1);
    chk("post_rst_dout", {24'd0, rx_if.dout}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones
    s0 = n_strobes;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(64);
    chk("par_ok_err", {31'd0, rx_if.parity_err}, 32'd0);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(64);
    chk("par_bad_err", {31'd0, rx_if.parity_err}, 32'd1);
    chk("par_strobes", n_strobes - s0, 32'd2);
`endif

    wait_clks(100);
    chk("final_queue", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
